// File: rtl/bit_enum_pkg.sv
// Shared definitions for the set-bit enumerator slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   state_t    - enumerator FSM states (ST_IDLE, ST_EMIT)
//   DEF_WIDTH  - default mask width
//   DEF_IDX_W  - default index width (one extra MSB so all-ones means "no bit")
//   IDX_NONE   - the encoder's "no bit" code (-1) at the default index width
package bit_enum_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_IDX_W = $clog2(DEF_WIDTH) + 1;

    // All-ones at the index width reads as -1 in two's complement. The extra
    // MSB of the index guarantees this never collides with a real bit index.
    localparam logic [DEF_IDX_W-1:0] IDX_NONE = '1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

endpackage : bit_enum_pkg

// File: rtl/bit_enum_msb_scan.sv
// Combinational priority encoder: index of the highest set bit, or all-ones if none.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake.
//
// Ports:
//   mask - WIDTH-bit vector to scan
//   idx  - IDX_W-bit index of the selected set bit, all-ones (-1) for an empty mask
//
// Build option BIT_ENUM_LSB_FIRST_EN: the input is bit-reversed before the
// scan and the found position is mirrored back, so the same encoder picks
// the lowest set bit instead.
module msb_scan
    import bit_enum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] mask,
    output logic [IDX_W-1:0] idx
);

    logic [WIDTH-1:0] scan_vec;
    logic [IDX_W-1:0] pos;
    logic             hit;

`ifdef BIT_ENUM_LSB_FIRST_EN
    always_comb begin
        scan_vec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            scan_vec[i] = mask[WIDTH-1-i];
        end
    end
`else
    assign scan_vec = mask;
`endif

    // Ascending loop: the last assignment wins, so pos ends on the highest
    // set bit of scan_vec.
    always_comb begin
        pos = '0;
        hit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (scan_vec[i]) begin
                pos = IDX_W'(i);
                hit = 1'b1;
            end
        end
    end

`ifdef BIT_ENUM_LSB_FIRST_EN
    // Highest bit of the reversed vector is the lowest bit of the original.
    assign idx = hit ? (IDX_W'(WIDTH - 1) - pos) : '1;
`else
    assign idx = hit ? pos : '1;
`endif

endmodule : msb_scan

// File: rtl/bit_enum.sv
// Set-bit enumerator: takes a mask, then streams each set-bit index one per beat.
// Latency: first beat the cycle after the mask is accepted; one beat per cycle after that.
// Backpressure: out_ready=0 freezes the current beat; in_ready is low until the mask is drained.
//
// Ports:
//   clk, rst   - rising-edge clock, synchronous active-high reset
//   in_valid   - mask offered           in_ready  - block is idle and can take a mask
//   in_mask    - mask to enumerate (sampled only on an accepted handshake)
//   out_valid  - beat present           out_ready - consumer takes the beat
//   out_idx    - set-bit index, all-ones (-1) for an empty mask
//   out_last   - final beat of the current mask
//   out_cnt    - zero-based beat number within the current mask
//
// Build option BIT_ENUM_LSB_FIRST_EN: enumerate lowest set bit first instead
// of highest first. Empty-mask behaviour is identical in both orders.
module bit_enum
    import bit_enum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic [IDX_W-1:0] out_cnt
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mask_r, mask_nxt;
    logic [IDX_W-1:0] cnt, cnt_nxt;

    logic [IDX_W-1:0] scan_idx;
    logic             mask_empty;
    logic             last_bit;
    logic [WIDTH-1:0] clr_bit;

    msb_scan #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_scan (
        .mask (mask_r),
        .idx  (scan_idx)
    );

    assign mask_empty = (mask_r == '0);

    // At most one bit set: clearing the lowest set bit leaves nothing.
    // Also true for the empty mask, which therefore emits a single last beat.
    assign last_bit = ((mask_r & (mask_r - WIDTH'(1))) == '0);

    // One-hot of the bit being emitted. The low index bits are all that is
    // needed; the MSB is only ever set for the "no bit" code, which clears nothing.
    assign clr_bit = mask_empty ? '0 : (WIDTH'(1) << scan_idx[IDX_W-2:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            mask_r <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            mask_r <= mask_nxt;
            cnt    <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mask_nxt  = mask_r;
        cnt_nxt   = cnt;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mask_nxt  = in_mask;
                    cnt_nxt   = '0;
                    state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    mask_nxt = mask_r & ~clr_bit;
                    cnt_nxt  = cnt + IDX_W'(1);
                    if (last_bit) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Beat fields come purely from registered state. They are forced to zero
    // outside EMIT so the idle/reset view is all-zero rather than showing the
    // "no bit" code of a cleared mask.
    assign out_idx  = out_valid ? scan_idx : '0;
    assign out_last = out_valid & last_bit;
    assign out_cnt  = out_valid ? cnt : '0;

endmodule : bit_enum

// File: tb/tb_bit_enum.sv
module tb_bit_enum;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_mask;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_idx;
    logic       out_last;
    logic [3:0] out_cnt;

    typedef struct packed {
        logic [3:0] idx;
        logic       last;
        logic [3:0] cnt;
    } beat_t;

    beat_t q[$];
    int    compared    = 0;
    int    mismatched  = 0;
    int    emit_cycles = 0;

    bit_enum #(.WIDTH(8), .IDX_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_cnt   (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: beats a mask should produce, in emission order.
    task automatic push_mask(input logic [7:0] m);
        beat_t b;
        int    n;
        int    k;
        int    bitpos;
        if (m == 8'h00) begin
            b.idx  = 4'hF;
            b.last = 1'b1;
            b.cnt  = 4'h0;
            q.push_back(b);
        end else begin
            n = 0;
            for (int i = 0; i < 8; i++) if (m[i]) n++;
            k = 0;
            for (int i = 0; i < 8; i++) begin
`ifdef BIT_ENUM_LSB_FIRST_EN
                bitpos = i;
`else
                bitpos = 7 - i;
`endif
                if (m[bitpos]) begin
                    b.idx  = 4'(bitpos);
                    b.last = (k == n - 1);
                    b.cnt  = 4'(k);
                    q.push_back(b);
                    k++;
                end
            end
        end
    endtask

    // Evaluate the current cycle (inputs already driven), then advance one edge.
    task automatic cyc();
        bit acc;
        acc = in_valid && in_ready && !rst;
        if (acc) push_mask(in_mask);
        if (out_valid === 1'b1) begin
            emit_cycles++;
            chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
            chk("sb_nonempty", {31'd0, q.size() != 0}, 32'd1);
            if (q.size() != 0) begin
                chk("out_idx",  {28'd0, out_idx},  {28'd0, q[0].idx});
                chk("out_last", {31'd0, out_last}, {31'd0, q[0].last});
                chk("out_cnt",  {28'd0, out_cnt},  {28'd0, q[0].cnt});
                if (out_ready && !rst) void'(q.pop_front());
            end
        end
        @(posedge clk);
        #1;
        if (acc) chk("first_beat_latency", {31'd0, out_valid}, 32'd1);
    endtask

    // mode 0: out_ready always 1; 1: toggle 1,0,1,0...; 2: random.
    task automatic drain(input int budget, input int mode);
        int i;
        i = 0;
        while (q.size() != 0 && i < budget) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (i % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            cyc();
            i++;
        end
        chk("drain_done", q.size(), 32'd0);
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_in_ready",  {31'd0, in_ready},  32'd1);
        out_ready = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_mask   = 8'hFF;
        out_ready = 1'b1;

        // Reset with a handshake offered: reset must win.
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_idx",   {28'd0, out_idx},   32'd0);
        chk("rst_out_last",  {31'd0, out_last},  32'd0);
        chk("rst_out_cnt",   {28'd0, out_cnt},   32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        cyc();
        chk("post_rst_idle", {31'd0, out_valid}, 32'd0);

        // Sparse mask, continuous out_ready.
        emit_cycles = 0;
        in_valid = 1'b1; in_mask = 8'b1010_0100;
        cyc();
        in_valid = 1'b0;
        drain(20, 0);
        chk("a4_emit_cycles", emit_cycles, 32'd3);

        // Empty mask: single "no bit" beat.
        emit_cycles = 0;
        in_valid = 1'b1; in_mask = 8'h00;
        cyc();
        in_valid = 1'b0;
        drain(10, 0);
        chk("empty_emit_cycles", emit_cycles, 32'd1);

        // Full mask with alternating backpressure.
        emit_cycles = 0;
        in_valid = 1'b1; in_mask = 8'hFF;
        cyc();
        in_valid = 1'b0;
        drain(40, 1);
        chk("ff_emit_cycles", emit_cycles, 32'd15);

        // Reset after the second beat of 8'hF0.
        in_valid = 1'b1; in_mask = 8'b1111_0000;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        q.delete();
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("midrst_out_cnt",   {28'd0, out_cnt},   32'd0);
        rst = 1'b0;
        emit_cycles = 0;
        in_valid = 1'b1; in_mask = 8'h01;
        cyc();
        in_valid = 1'b0;
        drain(10, 0);
        chk("midrst_emit_cycles", emit_cycles, 32'd1);

        // in_valid held high, in_mask changing during EMIT.
        in_valid = 1'b1; in_mask = 8'h81;
        cyc();
        in_mask = 8'h3C;
        cyc();
        in_mask = 8'h5A;
        cyc();
        chk("held_idle_in_ready", {31'd0, in_ready}, 32'd1);
        in_mask = 8'h42;
        cyc();
        in_valid = 1'b0;
        in_mask  = 8'hFF;
        drain(20, 0);

        // A few random masks under random backpressure.
        for (int r = 0; r < 8; r++) begin
            in_valid = 1'b1;
            in_mask  = 8'($urandom_range(0, 255));
            cyc();
            in_valid = 1'b0;
            drain(200, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_bit_enum
